lsu_ic0_mst: RTL and testbench
==============================

// Module: lsu_ic0_mst
// PURPOSE
//  Load/store initiator for the ic0 data bus. Accepts byte/half/word requests from the core and drives ic0 master signals.
//  Responder is a 32-bit word memory: sync read with 1-cycle latency, full-word writes only (no byte enables).
//  Sub-word stores are therefore done as read-modify-write. Sits between the core execute stage and the ic0 data interconnect.
// PARAMETERS
//  DMEM_HI   16'h0000  required value of addr[31:16] for a mapped write; reads use slave rd_ready instead
// PORTS
//  clk                      in   1   single clock, all logic on posedge
//  reset                    in   1   synchronous, active-high
//  req_valid                in   1   core request strobe
//  req_ready                out  1   block can accept request (IDLE only)
//  req_we                   in   1   1=store, 0=load
//  req_size                 in   2   0=byte, 1=half, 2=word (3 illegal -> err)
//  req_unsigned             in   1   load zero-extend (1) / sign-extend (0)
//  req_addr                 in   32  byte address
//  req_wdata                in   32  store data, LSB-aligned
//  rsp_valid                out  1   one-cycle completion pulse, no backpressure
//  rsp_rdata                out  32  load result, extended; 0 for stores/errors
//  rsp_err                  out  1   misaligned / illegal size / unmapped / RMW disabled
//  ic0_c_axi_mst_rd_valid   out  1   read strobe
//  ic0_axi_mst_rd_addr      out  32  read byte address, word-aligned
//  ic0_c_axi_slv_rd_ready   in   1   slave decodes rd_addr (same cycle as rd_valid)
//  ic0_axi_slv_rd_data      in   32  read data, valid cycle after rd_valid
//  ic0_c_axi_mst_wr_valid   out  1   write strobe, one cycle per write
//  ic0_axi_mst_wr_addr      out  32  write byte address, word-aligned
//  ic0_axi_mst_wr_data      out  32  full-word write data
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=1; rsp_valid, rsp_err, rd_valid, wr_valid=0; rsp_rdata, addrs, wr_data=0.
//  Reset mid-op aborts: no wr_valid may follow reset; no rsp for the aborted request.
//  All ic0 outputs and rsp_* are registered. Request latched on req_valid&&req_ready (cycle T).
//  FSM: IDLE -> RD_ADDR -> RD_DATA -> (RESP | WR) ; IDLE -> WR ; IDLE -> RESP (error); WR -> RESP; RESP -> IDLE.
//   IDLE: on accept, check first. Error if half with addr[0]=1, word with addr[1:0]!=0, or size=3 -> RESP, err=1.
//     Error also for store with addr[31:16]!=DMEM_HI. Then: load or sub-word store -> RD_ADDR; word store -> WR.
//   RD_ADDR: rd_valid=1, rd_addr={addr[31:2],2'b00}; sample rd_ready; if 0 -> RESP with err=1.
//   RD_DATA: capture rd_data. Load -> RESP with extracted lane (byte lane addr[1:0], half lane addr[1]), extended per req_unsigned.
//     Sub-word store -> merge req_wdata lane into captured word -> WR.
//   WR: wr_valid=1 for exactly one cycle, wr_addr word-aligned, wr_data=merged or req_wdata -> RESP.
//   RESP: rsp_valid=1 one cycle -> IDLE; req_ready returns to 1 next cycle.
//  Latency accept->rsp_valid: load T+3, word store T+2, sub-word store T+4, early error T+1, unmapped load T+2.
//  rd_valid and wr_valid never asserted in the same cycle. Back-to-back: next accept earliest the cycle after rsp_valid.
//  Address wrap: 32'hFFFF_FFFC treated as any other address (unmapped -> err); no increment logic.
// CONFIGURATION
//  LSU_RMW_EN defined: sub-word stores use RD_ADDR/RD_DATA/WR RMW as above.
//  LSU_RMW_EN undefined: sub-word stores rejected in IDLE -> RESP err=1, no bus activity. Loads and word stores unchanged.
// STRUCTURE
//  lsu_pkg: size enum (SZ_B, SZ_H, SZ_W), state enum (IDLE, RD_ADDR, RD_DATA, WR, RESP), DMEM_HI default.
//  Sub-module lsu_lane_align (combinational): extract+extend for loads, lane merge for stores.
// TESTING
//  LW 0x0000_0010, mem=0xDEAD_BEEF -> rd_valid at T+1 addr 0x10; rsp T+3 rdata=0xDEAD_BEEF, err=0.
//  LB signed 0x13 and LBU 0x13, mem=0x80FF_0000 -> rdata 0xFFFF_FF80 / 0x0000_0080.
//  SB 0x0000_0021 data 0xAB, mem=0x1122_3344 -> one wr_valid at T+3, wr_data=0x1122_AB44; rsp T+4.
//  SW 0x0000_0008 data 0xCAFE_F00D -> wr_valid T+1 only, no rd_valid; rsp T+2.
//  LH 0x0000_0003 -> rsp T+1 err=1, no bus activity; SW 0x0001_0000 -> err=1, no wr_valid.
//  Reset asserted in RD_DATA of an SB -> no wr_valid, no rsp; req_ready=1 the cycle after reset releases.
//  LSU_RMW_EN undefined: SH 0x0000_0002 -> rsp T+1 err=1, no bus activity.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the ic0 load/store initiator.
// Optional build macro LSU_RMW_EN is consumed by lsu_ic0_mst.
package lsu_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam logic [15:0] DMEM_HI_DEFAULT = 16'h0000;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR,
        RESP
    } state_e;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/lsu_ic0_mst_if.sv
// ic0 data-bus signal bundle: master drives read/write strobes, slave returns read decode and data.
interface lsu_ic0_mst_if;
    import lsu_pkg::*;

    logic              ic0_c_axi_mst_rd_valid;
    logic [ADDR_W-1:0] ic0_axi_mst_rd_addr;
    logic              ic0_c_axi_slv_rd_ready;
    logic [DATA_W-1:0] ic0_axi_slv_rd_data;
    logic              ic0_c_axi_mst_wr_valid;
    logic [ADDR_W-1:0] ic0_axi_mst_wr_addr;
    logic [DATA_W-1:0] ic0_axi_mst_wr_data;

    modport mst (
        output ic0_c_axi_mst_rd_valid, ic0_axi_mst_rd_addr,
        input  ic0_c_axi_slv_rd_ready, ic0_axi_slv_rd_data,
        output ic0_c_axi_mst_wr_valid, ic0_axi_mst_wr_addr, ic0_axi_mst_wr_data
    );

    modport slv (
        input  ic0_c_axi_mst_rd_valid, ic0_axi_mst_rd_addr,
        output ic0_c_axi_slv_rd_ready, ic0_axi_slv_rd_data,
        input  ic0_c_axi_mst_wr_valid, ic0_axi_mst_wr_addr, ic0_axi_mst_wr_data
    );

endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: extract+extend a load lane, or merge a store lane into a read word.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [DATA_W-1:0] word_i,
    input  logic [1:0]        addr_lo_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] load_o,
    output logic [DATA_W-1:0] merge_o
);

    logic [7:0]  byte_c;
    logic [15:0] half_c;

    always_comb begin
        byte_c  = word_i[7:0];
        half_c  = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
        load_o  = word_i;
        merge_o = wdata_i;

        unique case (addr_lo_i)
            2'd0: byte_c = word_i[7:0];
            2'd1: byte_c = word_i[15:8];
            2'd2: byte_c = word_i[23:16];
            2'd3: byte_c = word_i[31:24];
        endcase

        if (size_i == 2'(SZ_B)) begin
            load_o  = {{24{~unsigned_i & byte_c[7]}}, byte_c};
            merge_o = word_i;
            unique case (addr_lo_i)
                2'd0: merge_o[7:0]   = wdata_i[7:0];
                2'd1: merge_o[15:8]  = wdata_i[7:0];
                2'd2: merge_o[23:16] = wdata_i[7:0];
                2'd3: merge_o[31:24] = wdata_i[7:0];
            endcase
        end else if (size_i == 2'(SZ_H)) begin
            load_o  = {{16{~unsigned_i & half_c[15]}}, half_c};
            merge_o = word_i;
            if (addr_lo_i[1]) merge_o[31:16] = wdata_i[15:0];
            else              merge_o[15:0]  = wdata_i[15:0];
        end
    end

endmodule

// File: rtl/lsu_ic0_mst.sv
// Load/store initiator for the ic0 word memory; sub-word stores are read-modify-write.
// Define LSU_RMW_EN to enable sub-word stores; otherwise they are rejected with an error.
module lsu_ic0_mst
    import lsu_pkg::*;
#(
    parameter logic [15:0] DMEM_HI = DMEM_HI_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    lsu_ic0_mst_if.mst        ic0
);

    state_e            state_q;
    logic              we_q, uns_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic              req_ready_q, rsp_valid_q, rsp_err_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rd_valid_q, wr_valid_q;
    logic [ADDR_W-1:0] rd_addr_q, wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;

    logic [DATA_W-1:0] load_data, merge_data;
    logic              acc_err_c;

    // Request checks evaluated on the raw inputs in the accept cycle.
    always_comb begin
        acc_err_c = (req_size == 2'd3)
                 || ((req_size == 2'(SZ_H)) && req_addr[0])
                 || ((req_size == 2'(SZ_W)) && (req_addr[1:0] != 2'b00))
                 || (req_we && (req_addr[31:16] != DMEM_HI));
`ifndef LSU_RMW_EN
        if (req_we && (req_size != 2'(SZ_W))) acc_err_c = 1'b1;
`endif
    end

    lsu_lane_align u_align (
        .word_i     (ic0.ic0_axi_slv_rd_data),
        .addr_lo_i  (addr_q[1:0]),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .wdata_i    (wdata_q),
        .load_o     (load_data),
        .merge_o    (merge_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            size_q      <= 2'd0;
            addr_q      <= '0;
            wdata_q     <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            rd_valid_q  <= 1'b0;
            wr_valid_q  <= 1'b0;
            rd_addr_q   <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid && req_ready_q) begin
                        req_ready_q <= 1'b0;
                        we_q        <= req_we;
                        size_q      <= req_size;
                        uns_q       <= req_unsigned;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        if (acc_err_c) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                        end else if (req_we && (req_size == 2'(SZ_W))) begin
                            state_q    <= WR;
                            wr_valid_q <= 1'b1;
                            wr_addr_q  <= word_align(req_addr);
                            wr_data_q  <= req_wdata;
                        end else begin
                            state_q    <= RD_ADDR;
                            rd_valid_q <= 1'b1;
                            rd_addr_q  <= word_align(req_addr);
                        end
                    end
                end
                RD_ADDR: begin
                    rd_valid_q <= 1'b0;
                    if (ic0.ic0_c_axi_slv_rd_ready) begin
                        state_q <= RD_DATA;
                    end else begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                    end
                end
                // Read data arrives this cycle: finish a load or build the merged store word.
                RD_DATA: begin
                    if (we_q) begin
                        state_q    <= WR;
                        wr_valid_q <= 1'b1;
                        wr_addr_q  <= word_align(addr_q);
                        wr_data_q  <= merge_data;
                    end else begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= load_data;
                    end
                end
                WR: begin
                    wr_valid_q  <= 1'b0;
                    state_q     <= RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= '0;
                end
                RESP: begin
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= '0;
                    req_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    assign ic0.ic0_c_axi_mst_rd_valid = rd_valid_q;
    assign ic0.ic0_axi_mst_rd_addr    = rd_addr_q;
    assign ic0.ic0_c_axi_mst_wr_valid = wr_valid_q;
    assign ic0.ic0_axi_mst_wr_addr    = wr_addr_q;
    assign ic0.ic0_axi_mst_wr_data    = wr_data_q;

endmodule

// File: tb/tb_lsu_ic0_mst.sv
// Self-checking bench for lsu_ic0_mst: cycle-indexed expectation model plus a small word-memory slave.
module tb_lsu_ic0_mst;

`ifdef LSU_RMW_EN
    localparam bit RMW_EN = 1'b1;
`else
    localparam bit RMW_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    lsu_ic0_mst_if bus();

    lsu_ic0_mst dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .ic0          (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave: 16-word memory, 1-cycle read latency, decodes only addr[31:16]==0.
    logic [31:0] smem [16];
    logic [31:0] rd_data_q = 32'h0;
    logic        pre_we = 1'b0;
    logic [3:0]  pre_idx = 4'd0;
    logic [31:0] pre_dat = 32'h0;
    logic        deny = 1'b0;

    always @(posedge clk) begin
        if (pre_we) smem[pre_idx] <= pre_dat;
        else if (bus.ic0_c_axi_mst_wr_valid) smem[bus.ic0_axi_mst_wr_addr[5:2]] <= bus.ic0_axi_mst_wr_data;
        rd_data_q <= smem[bus.ic0_axi_mst_rd_addr[5:2]];
    end
    assign bus.ic0_axi_slv_rd_data    = rd_data_q;
    assign bus.ic0_c_axi_slv_rd_ready = bus.ic0_c_axi_mst_rd_valid
                                      && (bus.ic0_axi_mst_rd_addr[31:16] == 16'h0) && !deny;

    // Model state
    logic [31:0] mmem [16];
    logic [31:0] e_rd_addr [int];
    logic [31:0] e_wr_addr [int];
    logic [31:0] e_wr_data [int];
    logic [31:0] e_rsp_data [int];
    logic        e_rsp_err [int];
    int busy_from = 0;
    int busy_until = -1;

    int n_cmp = 0;
    int n_fail = 0;
    int rd_cnt = 0, wr_cnt = 0, rsp_cnt = 0;
    int last_rsp_cyc = -1;
    logic [31:0] last_rdata = 32'h0, last_wr_data = 32'h0;
    logic last_err = 1'b0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h want %h", nm, cyc, act, exp);
        end
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] off,
                                            input logic [1:0] sz, input bit uns);
        logic [31:0] v;
        v = w >> (8 * int'(off));
        if (sz == 2'd0) begin
            v = v & 32'hFF;
            if (!uns && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = v & 32'hFFFF;
            if (!uns && v[15]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] wd,
                                          input logic [1:0] off, input logic [1:0] sz);
        logic [31:0] mask;
        mask = ((sz == 2'd0) ? 32'hFF : 32'hFFFF) << (8 * int'(off));
        return (w & ~mask) | ((wd << (8 * int'(off))) & mask);
    endfunction

    // Schedule every bus/response event of one request, relative to its accept cycle t.
    task automatic predict(input int t, input bit we, input logic [1:0] sz, input bit uns,
                           input logic [31:0] a, input logic [31:0] wd, input bit dn);
        int rsp_at;
        bit err, mapped, bad;
        logic [31:0] rd;
        mapped = (a[31:16] == 16'h0);
        bad = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00)
           || (we && !mapped) || (we && sz != 2'd2 && !RMW_EN);
        err = 1'b0;
        rd = 32'h0;
        if (bad) begin
            rsp_at = t + 1; err = 1'b1;
        end else if (we && sz == 2'd2) begin
            e_wr_addr[t+1] = a & ~32'h3;
            e_wr_data[t+1] = wd;
            mmem[a[5:2]] = wd;
            rsp_at = t + 2;
        end else begin
            e_rd_addr[t+1] = a & ~32'h3;
            if (!mapped || dn) begin
                rsp_at = t + 2; err = 1'b1;
            end else if (!we) begin
                rsp_at = t + 3;
                rd = extract(mmem[a[5:2]], a[1:0], sz, uns);
            end else begin
                e_wr_addr[t+3] = a & ~32'h3;
                e_wr_data[t+3] = merge(mmem[a[5:2]], wd, a[1:0], sz);
                mmem[a[5:2]] = e_wr_data[t+3];
                rsp_at = t + 4;
            end
        end
        e_rsp_data[rsp_at] = rd;
        e_rsp_err[rsp_at]  = err;
        busy_from  = t + 1;
        busy_until = rsp_at;
    endtask

    // Per-cycle comparison of every DUT output against the schedule.
    task automatic monitor();
        forever begin
            @(negedge clk);
            chk("rd_valid", 32'(bus.ic0_c_axi_mst_rd_valid), 32'(e_rd_addr.exists(cyc)));
            if (e_rd_addr.exists(cyc)) chk("rd_addr", bus.ic0_axi_mst_rd_addr, e_rd_addr[cyc]);
            chk("wr_valid", 32'(bus.ic0_c_axi_mst_wr_valid), 32'(e_wr_addr.exists(cyc)));
            if (e_wr_addr.exists(cyc)) begin
                chk("wr_addr", bus.ic0_axi_mst_wr_addr, e_wr_addr[cyc]);
                chk("wr_data", bus.ic0_axi_mst_wr_data, e_wr_data[cyc]);
            end
            chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp_err.exists(cyc)));
            if (e_rsp_err.exists(cyc)) begin
                chk("rsp_rdata", rsp_rdata, e_rsp_data[cyc]);
                chk("rsp_err", 32'(rsp_err), 32'(e_rsp_err[cyc]));
            end
            chk("req_ready", 32'(req_ready), 32'(!(cyc >= busy_from && cyc <= busy_until)));
            if (bus.ic0_c_axi_mst_rd_valid) rd_cnt++;
            if (bus.ic0_c_axi_mst_wr_valid) begin wr_cnt++; last_wr_data = bus.ic0_axi_mst_wr_data; end
            if (rsp_valid) begin
                rsp_cnt++; last_rsp_cyc = cyc; last_rdata = rsp_rdata; last_err = rsp_err;
            end
        end
    endtask

    task automatic preload(input logic [3:0] idx, input logic [31:0] dat);
        pre_we = 1'b1; pre_idx = idx; pre_dat = dat;
        mmem[idx] = dat;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Present one request at a negedge; returns the accept cycle, or -1 if never ready.
    task automatic start(input bit we, input logic [1:0] sz, input bit uns,
                         input logic [31:0] a, input logic [31:0] wd, input bit dn, output int t);
        int k;
        k = 0;
        while (!req_ready && k < 20) begin @(negedge clk); k++; end
        if (!req_ready) begin
            chk("req_ready_timeout", 32'(req_ready), 32'd1);
            t = -1;
            return;
        end
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd; deny = dn;
        t = cyc;
        predict(t, we, sz, uns, a, wd, dn);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic finish_op();
        while (cyc <= busy_until) @(negedge clk);
    endtask

    task automatic op(input bit we, input logic [1:0] sz, input bit uns,
                      input logic [31:0] a, input logic [31:0] wd, output int t);
        start(we, sz, uns, a, wd, 1'b0, t);
        finish_op();
    endtask

    initial begin
        int t, rd0, wr0, rsp0;
        logic [31:0] saved;
        @(negedge clk);
        fork monitor(); join_none
        for (int i = 0; i < 16; i++) preload(4'(i), $urandom);
        chk("rst_rd_addr", bus.ic0_axi_mst_rd_addr, 32'h0);
        chk("rst_wr_addr", bus.ic0_axi_mst_wr_addr, 32'h0);
        chk("rst_wr_data", bus.ic0_axi_mst_wr_data, 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        reset = 1'b0;
        @(negedge clk);

        // LW aligned
        preload(4'd4, 32'hDEAD_BEEF);
        rd0 = rd_cnt;
        op(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0, t);
        chk("lw_data", last_rdata, 32'hDEAD_BEEF);
        chk("lw_lat", 32'(last_rsp_cyc - t), 32'd3);
        chk("lw_rd_cnt", 32'(rd_cnt - rd0), 32'd1);

        // LB / LBU on top byte
        preload(4'd4, 32'h80FF_0000);
        op(1'b0, 2'd0, 1'b0, 32'h0000_0013, 32'h0, t);
        chk("lb_data", last_rdata, 32'hFFFF_FF80);
        op(1'b0, 2'd0, 1'b1, 32'h0000_0013, 32'h0, t);
        chk("lbu_data", last_rdata, 32'h0000_0080);

        // SB read-modify-write
        preload(4'd8, 32'h1122_3344);
        wr0 = wr_cnt;
        op(1'b1, 2'd0, 1'b0, 32'h0000_0021, 32'h0000_00AB, t);
`ifdef LSU_RMW_EN
        chk("sb_wr_data", last_wr_data, 32'h1122_AB44);
        chk("sb_lat", 32'(last_rsp_cyc - t), 32'd4);
        chk("sb_wr_cnt", 32'(wr_cnt - wr0), 32'd1);
`else
        chk("sb_lat", 32'(last_rsp_cyc - t), 32'd1);
        chk("sb_err", 32'(last_err), 32'd1);
        chk("sb_wr_cnt", 32'(wr_cnt - wr0), 32'd0);
`endif

        // SW aligned: write only
        rd0 = rd_cnt; wr0 = wr_cnt;
        op(1'b1, 2'd2, 1'b0, 32'h0000_0008, 32'hCAFE_F00D, t);
        chk("sw_lat", 32'(last_rsp_cyc - t), 32'd2);
        chk("sw_wr_data", last_wr_data, 32'hCAFE_F00D);
        chk("sw_rd_cnt", 32'(rd_cnt - rd0), 32'd0);

        // Early errors, unmapped store, SH without RMW, top-of-space address
        rd0 = rd_cnt; wr0 = wr_cnt;
        op(1'b0, 2'd1, 1'b0, 32'h0000_0003, 32'h0, t);
        chk("lh_mis_lat", 32'(last_rsp_cyc - t), 32'd1);
        chk("lh_mis_err", 32'(last_err), 32'd1);
        op(1'b1, 2'd2, 1'b0, 32'h0001_0000, 32'h1234_5678, t);
        chk("sw_unmap_err", 32'(last_err), 32'd1);
        chk("err_bus_idle", 32'(rd_cnt - rd0 + wr_cnt - wr0), 32'd0);
`ifndef LSU_RMW_EN
        op(1'b1, 2'd1, 1'b0, 32'h0000_0002, 32'h0000_BEEF, t);
        chk("sh_norwm_lat", 32'(last_rsp_cyc - t), 32'd1);
        chk("sh_norwm_err", 32'(last_err), 32'd1);
`endif
        op(1'b0, 2'd2, 1'b0, 32'hFFFF_FFFC, 32'h0, t);
        chk("lw_wrap_lat", 32'(last_rsp_cyc - t), 32'd2);
        chk("lw_wrap_err", 32'(last_err), 32'd1);

        // Reset during RD_DATA of a sub-word store (or early error without RMW)
        saved = mmem[4'd5];
        wr0 = wr_cnt; rsp0 = rsp_cnt;
        start(1'b1, 2'd0, 1'b0, 32'h0000_0015, 32'h0000_0077, 1'b0, t);
        @(negedge clk);
        reset = 1'b1;
        foreach (e_rd_addr[k])  if (k > cyc) e_rd_addr.delete(k);
        foreach (e_wr_addr[k])  if (k > cyc) begin e_wr_addr.delete(k); e_wr_data.delete(k); end
        foreach (e_rsp_err[k])  if (k > cyc) begin e_rsp_err.delete(k); e_rsp_data.delete(k); end
        if (busy_until > cyc) busy_until = cyc;
        mmem[4'd5] = saved;
        @(negedge clk);
        reset = 1'b0;
        chk("post_rst_ready", 32'(req_ready), 32'd1);
        repeat (4) @(negedge clk);
`ifdef LSU_RMW_EN
        chk("rst_no_wr", 32'(wr_cnt - wr0), 32'd0);
        chk("rst_no_rsp", 32'(rsp_cnt - rsp0), 32'd0);
`endif

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            logic [1:0] sz;
            sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a = ($urandom_range(0, 9) == 0) ? $urandom : {26'h0, 6'($urandom)};
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            start(1'($urandom), sz, 1'($urandom), a, $urandom, ($urandom_range(0, 9) == 0), t);
            finish_op();
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
